// File: rtl/gamma_pkg.sv
// Shared defaults and state encoding for the gamma-cycle spike encoder.
package gamma_pkg;
   localparam int GAMMA_CYCLE_LENGTH_DEF = 18;
   localparam int PULSE_WIDTH_DEF        = 8;
   localparam int CNT_W                  = $clog2(GAMMA_CYCLE_LENGTH_DEF);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/gamma_spike_encoder_value2pulse.sv
// Per-channel temporal encoder: pulse is high for PULSE_WIDTH cycles starting at cycle 1 + value.
module value2pulse #(
   parameter int VRES        = 3,
   parameter int CW          = 5,
   parameter int PULSE_WIDTH = 8
) (
   input  logic [VRES-1:0] value,
   input  logic            en,
   input  logic [CW-1:0]   cycle_counter,
   output logic            pulse
);
   // One extra bit so start + PULSE_WIDTH never wraps.
   logic [CW:0] start, stop, cc;

   assign start = (CW+1)'(value) + (CW+1)'(1);
   assign stop  = start + (CW+1)'(PULSE_WIDTH);
   assign cc    = {1'b0, cycle_counter};
   assign pulse = en && (cc >= start) && (cc < stop);
endmodule

// File: rtl/gamma_spike_encoder.sv
// Gamma-cycle sequencer with a pending/active vector buffer driving P temporal spike encoders.
module gamma_spike_encoder
   import gamma_pkg::*;
#(
   parameter int P                  = 64,
   parameter int VRES               = 3,
   parameter int PULSE_WIDTH        = PULSE_WIDTH_DEF,
   parameter int GAMMA_CYCLE_LENGTH = GAMMA_CYCLE_LENGTH_DEF
) (
   input  logic                                  clk,
   input  logic                                  rstb,
   input  logic                                  run_en,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [P-1:0][VRES-1:0]                in_values,
   input  logic [P-1:0]                          in_spike_en,
   output logic [P-1:0]                          input_spikes,
   output logic [$clog2(GAMMA_CYCLE_LENGTH)-1:0] cycle_counter,
   output logic                                  grst,
   output logic                                  alt_grst,
   output logic                                  wave_valid
);
   localparam int          CW   = $clog2(GAMMA_CYCLE_LENGTH);
   localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_LENGTH - 1);

   if (1 + (2**VRES - 1) + PULSE_WIDTH > GAMMA_CYCLE_LENGTH) begin : g_len_chk
      $error("gamma_spike_encoder: latest pulse does not fit in one gamma cycle");
   end

   state_t                 state;
   logic                   pend_full;
   logic [P-1:0][VRES-1:0] pend_values, act_values;
   logic [P-1:0]           pend_en, act_en;
   logic                   xfer, load, running;

   assign running  = (state == RUN);
   assign in_ready = !pend_full;
   assign xfer     = in_valid && !pend_full;
   // Waves only start on a boundary: from IDLE or at the last cycle of a wave.
   assign load     = run_en && (!running || cycle_counter == LAST);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state         <= IDLE;
         cycle_counter <= '0;
         grst          <= 1'b0;
         alt_grst      <= 1'b0;
         wave_valid    <= 1'b0;
         pend_full     <= 1'b0;
         pend_values   <= '0;
         pend_en       <= '0;
         act_values    <= '0;
         act_en        <= '0;
      end else begin
         if (xfer) begin
            pend_values <= in_values;
            pend_en     <= in_spike_en;
         end
         // Load reads pre-edge pending, so a same-cycle transfer waits one wave.
         pend_full <= xfer | (pend_full & !load);
         grst      <= load;
         if (load) begin
            state         <= RUN;
            cycle_counter <= '0;
            alt_grst      <= running ? !alt_grst : 1'b0;
            wave_valid    <= pend_full;
            act_values    <= pend_full ? pend_values : '0;
            act_en        <= pend_full ? pend_en : '0;
         end else if (running) begin
            if (cycle_counter == LAST) begin
               state         <= IDLE;
               cycle_counter <= '0;
               alt_grst      <= 1'b0;
               wave_valid    <= 1'b0;
               act_en        <= '0;
            end else begin
               cycle_counter <= cycle_counter + CW'(1);
            end
         end
      end
   end

   for (genvar i = 0; i < P; i++) begin : g_ch
      value2pulse #(
         .VRES        (VRES),
         .CW          (CW),
         .PULSE_WIDTH (PULSE_WIDTH)
      ) u_v2p (
         .value         (act_values[i]),
         .en            (act_en[i] && running),
         .cycle_counter (cycle_counter),
         .pulse         (input_spikes[i])
      );
   end
endmodule

// File: tb/tb_gamma_spike_encoder.sv
// Randomized bench for gamma_spike_encoder against a wave-level reference model.
module tb_gamma_spike_encoder;
   import gamma_pkg::*;

   localparam int P    = 64;
   localparam int VRES = 3;
   localparam int G    = GAMMA_CYCLE_LENGTH_DEF;
   localparam int PW   = PULSE_WIDTH_DEF;

   typedef struct {
      logic [P-1:0][VRES-1:0] val;
      logic [P-1:0]           en;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rstb, run_en, in_valid, in_ready;
   logic [P-1:0][VRES-1:0] in_values;
   logic [P-1:0]           in_spike_en, input_spikes;
   logic [CNT_W-1:0]       cycle_counter;
   logic                   grst, alt_grst, wave_valid;

   int checks = 0;
   int errors = 0;

   // Reference model: wave position, ownership and vectors held as plain values/queue.
   bit   m_run, m_alt, m_wv;
   int   m_pos;
   vec_t m_act;
   vec_t pend_q[$];

   gamma_spike_encoder #(.P(P), .VRES(VRES), .PULSE_WIDTH(PW), .GAMMA_CYCLE_LENGTH(G)) dut (
      .clk(clk), .rstb(rstb), .run_en(run_en), .in_valid(in_valid), .in_ready(in_ready),
      .in_values(in_values), .in_spike_en(in_spike_en), .input_spikes(input_spikes),
      .cycle_counter(cycle_counter), .grst(grst), .alt_grst(alt_grst), .wave_valid(wave_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic vec_t empty_vec();
      vec_t v;
      v.val = '0;
      v.en  = '0;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < P; i++) v.val[i] = VRES'($urandom_range(0, 7));
      v.en = {$urandom, $urandom};
      return v;
   endfunction

   function automatic logic [P-1:0] exp_spikes();
      logic [P-1:0] s;
      for (int i = 0; i < P; i++) begin
         int t0 = 1 + int'(m_act.val[i]);
         s[i] = m_run && m_act.en[i] && (m_pos >= t0) && (m_pos < t0 + PW);
      end
      return s;
   endfunction

   task automatic model_reset();
      m_run = 0; m_alt = 0; m_wv = 0; m_pos = 0;
      m_act = empty_vec();
      pend_q.delete();
   endtask

   task automatic check_all();
      chk("counter", 64'(cycle_counter), 64'(m_pos));
      chk("grst", 64'(grst), 64'(m_run && m_pos == 0));
      chk("in_ready", 64'(in_ready), 64'(pend_q.size() == 0));
      chk("spikes", input_spikes, exp_spikes());
      chk("wave_valid", 64'(wave_valid), 64'(m_run && m_wv));
      if (m_run) chk("alt_grst", 64'(alt_grst), 64'(m_alt));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic step(input bit r, input bit v, input vec_t vec);
      bit boundary, load, accept;
      run_en = r; in_valid = v; in_values = vec.val; in_spike_en = vec.en;
      boundary = !m_run || (m_pos == G - 1);
      load     = boundary && r;
      accept   = v && (pend_q.size() == 0);
      if (load) begin
         if (pend_q.size() > 0) begin m_act = pend_q.pop_front(); m_wv = 1; end
         else begin m_act = empty_vec(); m_wv = 0; end
         m_alt = m_run ? !m_alt : 1'b0;
         m_run = 1;
         m_pos = 0;
      end else if (m_run) begin
         if (m_pos == G - 1) begin m_run = 0; m_pos = 0; end
         else m_pos++;
      end
      if (accept) pend_q.push_back(vec);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      vec_t d;
      rstb = 1'b0; run_en = 0; in_valid = 0; in_values = '0; in_spike_en = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_counter", 64'(cycle_counter), 0);
      chk("rst_spikes", input_spikes, 0);
      chk("rst_grst", 64'(grst), 0);
      rstb = 1'b1;

      // Idle with run_en low.
      for (int k = 0; k < 40; k++) step(0, 0, empty_vec());

      // Directed vector: ch0=0, ch1=7, ch2=3 enabled, ch3 disabled.
      d = empty_vec();
      d.val[0] = 3'd0; d.val[1] = 3'd7; d.val[2] = 3'd3; d.val[3] = 3'd5;
      d.en[2:0] = 3'b111;
      step(0, 1, d);
      for (int k = 0; k < G; k++) begin
         step(1, 0, empty_vec());
         case (m_pos)
            1:  chk("dir_pos1",  64'(input_spikes[3:0]), 64'h1);
            4:  chk("dir_pos4",  64'(input_spikes[3:0]), 64'h5);
            8:  chk("dir_pos8",  64'(input_spikes[3:0]), 64'h7);
            12: chk("dir_pos12", 64'(input_spikes[3:0]), 64'h2);
            15: chk("dir_pos15", 64'(input_spikes[3:0]), 64'h2);
            16: chk("dir_pos16", 64'(input_spikes[3:0]), 64'h0);
            default: ;
         endcase
      end

      // Continuous run, new vector offered every cycle, then sparse offers for bubbles.
      for (int k = 0; k < 4 * G; k++) step(1, 1, rand_vec());
      for (int k = 0; k < 10 * G; k++) step(1, ($urandom % 20) == 0, rand_vec());

      // in_valid at the last wave cycle with pending empty: bubble then vector.
      for (int k = 0; k < 3 * G && !(m_pos == G - 1 && pend_q.size() == 0); k++)
         step(1, 0, empty_vec());
      chk("bubble_setup", 64'(m_pos == G - 1 && pend_q.size() == 0), 1);
      step(1, 1, rand_vec());
      for (int k = 0; k < 2 * G; k++) step(1, 0, empty_vec());

      // Drop run_en mid-wave, idle, then restart.
      for (int k = 0; k < 2 * G && m_pos != 5; k++) step(1, 1, rand_vec());
      for (int k = 0; k < 2 * G; k++) step(0, 0, empty_vec());
      for (int k = 0; k < 3 * G; k++) step(1, ($urandom % 3) == 0, rand_vec());

      // Reset mid-wave with pending full.
      for (int k = 0; k < 3 * G && !(m_pos == 10 && pend_q.size() == 1); k++)
         step(1, 1, rand_vec());
      chk("rst_setup", 64'(m_pos == 10 && pend_q.size() == 1), 1);
      rstb = 1'b0;
      #1;
      chk("arst_counter", 64'(cycle_counter), 0);
      chk("arst_spikes", input_spikes, 0);
      chk("arst_wave_valid", 64'(wave_valid), 0);
      chk("arst_alt", 64'(alt_grst), 0);
      chk("arst_ready", 64'(in_ready), 1);
      model_reset();
      run_en = 0; in_valid = 0;
      @(negedge clk);
      rstb = 1'b1;
      for (int k = 0; k < 3 * G; k++) step(1, 0, empty_vec());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gamma_spike_encoder.md
Name: gamma_spike_encoder

Overview:
Upstream stage of the multiplexed TNN column. Accepts input vectors (P channels of VRES-bit values plus per-channel spike-enable) through a valid/ready handshake and buffers one of them. Converts each vector into temporally encoded input_spikes pulses within one gamma cycle. Generates the gamma-cycle control the column consumes: cycle_counter, grst, and alt_grst, which selects which of the two multiplexed networks owns the current wave.

Parameters:
P, 64, number of input channels (matches column P)
VRES, 3, bit width of each input value; spike time = value
PULSE_WIDTH, 8, input spike pulse width in clk cycles (wmax+1)
GAMMA_CYCLE_LENGTH, 18, clk cycles per gamma cycle; elaboration check requires 1 + (2^VRES - 1) + PULSE_WIDTH <= GAMMA_CYCLE_LENGTH

Ports:
clk  in  1  unit clock
rstb  in  1  asynchronous active-low reset
run_en  in  1  enables gamma cycling; sampled at wave boundaries
in_valid  in  1  input vector valid
in_ready  out  1  pending buffer can accept a vector
in_values  in  P*VRES  per-channel spike time, packed [P-1:0][VRES-1:0]
in_spike_en  in  P  per-channel enable; 0 = channel never spikes this wave
input_spikes  out  P  pulses to the column
cycle_counter  out  $clog2(GAMMA_CYCLE_LENGTH)  position within the gamma cycle
grst  out  1  one-cycle pulse at gamma-cycle start
alt_grst  out  1  network select for the current wave (0 = network 0)
wave_valid  out  1  current wave carries a real vector; 0 = bubble

Behaviour:
- Reset (rstb low, asynchronous): state IDLE, cycle_counter 0, grst 0, alt_grst 0, wave_valid 0, input_spikes 0, pending empty, active vector cleared. in_ready = 1 once reset is released. Reset mid-wave drops both the pending and the active vector.
- FSM states: IDLE and RUN.
  - IDLE: cycle_counter held at 0; grst 0; input_spikes 0.
  - IDLE -> RUN when run_en = 1 (load event). In the next cycle cycle_counter = 0, grst = 1, alt_grst = 0.
- RUN:
  - cycle_counter increments by 1 each cycle and wraps from GAMMA_CYCLE_LENGTH-1 to 0.
  - grst = 1 exactly when cycle_counter == 0.
  - At cycle_counter == GAMMA_CYCLE_LENGTH-1: if run_en = 1, this is a load event and alt_grst toggles for the next wave. If run_en = 0, go to IDLE after the current wave completes. A wave is never truncated.
- Buffering:
  - One pending register plus one active register.
  - in_ready = !pending_full (combinational from registered state).
  - Transfer occurs when in_valid && in_ready. The pending register captures in_values and in_spike_en and becomes full.
- Load event:
  - If pending is full, active <= pending, pending becomes empty, and wave_valid = 1 for the next wave.
  - If pending is empty, active is cleared to all channels disabled and wave_valid = 0 (bubble; the wave still runs and alt_grst still alternates).
  - A transfer in the same cycle as a load event lands in pending after the edge; the load uses the pre-edge pending contents. An empty pending plus simultaneous in_valid therefore yields a bubble, and the new vector goes to the following wave.
- Spike generation, per channel i, registered from active state:
  - input_spikes[i] = 1 iff RUN, the channel is enabled, and 1 + value_i <= cycle_counter < 1 + value_i + PULSE_WIDTH.
  - Earliest spike is at cycle 1, one clk after grst. Value 7 spikes at cycles 8..15.
  - Outputs are combinational from cycle_counter and the active register, with no extra latency.
- Latency: a vector accepted when pending is empty appears in the next wave that starts after a load event. Minimum is 1 cycle (accepted at counter G-2). Maximum is one full gamma cycle plus 1 cycle.
- Arithmetic: comparisons are done at $clog2(GAMMA_CYCLE_LENGTH)+1 bits so that 1 + value + PULSE_WIDTH cannot overflow.

Decomposition:
- Package gamma_pkg: GAMMA_CYCLE_LENGTH and PULSE_WIDTH defaults, the counter-width constant, and the state enum (IDLE, RUN).
- One sub-module, value2pulse: per-channel comparator taking value, enable and cycle_counter and producing the pulse. Instantiated P times in a generate loop. The FSM, counter and buffers live in the top module.

Test Plan:
- Reset release, run_en = 0, 40 cycles -> cycle_counter = 0, grst = 0, input_spikes = 0, in_ready = 1 throughout.
- Accept values ch0 = 0, ch1 = 7, ch2 = 3 with en = 1 and ch3 en = 0, then raise run_en -> grst at counter 0; ch0 high at counters 1..8, ch1 at 8..15, ch2 at 4..11, ch3 never; wave_valid = 1, alt_grst = 0.
- Continuous run_en with a new vector every wave -> grst every 18 cycles; alt_grst alternates 0, 1, 0, 1; in_ready drops after each accept and recovers at each load.
- No vector supplied for one wave -> wave_valid = 0 and input_spikes = 0 for that wave, while alt_grst still toggles. in_valid asserted at counter 17 with pending empty -> that wave is a bubble and the vector appears in the following wave.
- Deassert run_en at counter 5 -> wave completes through counter 17, then IDLE with counter held at 0. Reassert -> alt_grst restarts at 0.
- Assert rstb low at counter 10 with pending full -> immediate clear of all outputs and pending. After release, the old vector never appears.
